// File: rtl/rams_sdp_be_pipe_if.sv
// Bus bundle for the simple-dual-port byte-enable RAM: write port A, read port B, status.
interface rams_sdp_be_pipe_if #(
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8,
    parameter int ADDR_WIDTH = 10
);
    localparam int NB_COL = DATA_WIDTH / BYTE_WIDTH;

    logic                  ena;
    logic [NB_COL-1:0]     wea;
    logic [ADDR_WIDTH-1:0] addra;
    logic [DATA_WIDTH-1:0] dia;
    logic                  enb;
    logic [ADDR_WIDTH-1:0] addrb;
    logic [DATA_WIDTH-1:0] dob;
    logic                  dob_valid;
    logic                  busy;

    modport master (
        output ena, wea, addra, dia, enb, addrb,
        input  dob, dob_valid, busy
    );

    modport slave (
        input  ena, wea, addra, dia, enb, addrb,
        output dob, dob_valid, busy
    );
endinterface

// File: rtl/rams_sdp_be_pipe.sv
// Simple-dual-port block RAM with byte-lane writes, 1/2-cycle registered reads,
// a post-reset clear sequencer and a selectable same-address collision policy.
module rams_sdp_be_pipe #(
    parameter int DATA_WIDTH     = 32,
    parameter int BYTE_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 10,
    parameter int DATA_DEPTH     = 1024,
    parameter int READ_LATENCY   = 1,
    parameter int COLLISION_MODE = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input logic                clk,
    input logic                rst,
    rams_sdp_be_pipe_if.slave  bus
);
    localparam int NB_COL = DATA_WIDTH / BYTE_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] CNT_LAST = ADDR_WIDTH'(DATA_DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_W  = (ADDR_WIDTH + 1)'(DATA_DEPTH);

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    state_t                r_state;
    state_t                w_nextState;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [DATA_WIDTH-1:0] r_ram [DATA_DEPTH];

    logic                  w_busy;
    logic                  w_clrWe;
    logic                  w_wrEn;
    logic                  w_rdEn;
    logic                  w_rdInRange;
    logic [NB_COL-1:0]     w_fwdMask;

    logic                  r_s1Valid;
    logic [DATA_WIDTH-1:0] r_s1Data;
    logic [NB_COL-1:0]     r_s1Mask;
    logic [DATA_WIDTH-1:0] r_s1Dia;
    logic [DATA_WIDTH-1:0] w_s1Merged;

    if ((DATA_WIDTH % BYTE_WIDTH) != 0) begin : g_badWidth
        $error("DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_nextState;
            if (r_state == S_CLEAR) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_CLEAR: if (r_cnt == CNT_LAST) w_nextState = S_RUN;
            S_RUN:   w_nextState = S_RUN;
            default: w_nextState = S_RUN;
        endcase
    end

    // Requests on either port are only honoured in RUN and never on a reset edge.
    always_comb begin
        w_busy      = (r_state == S_CLEAR);
        w_clrWe     = w_busy & ~rst;
        w_wrEn      = (r_state == S_RUN) & ~rst & bus.ena & ({1'b0, bus.addra} < DEPTH_W);
        w_rdEn      = (r_state == S_RUN) & ~rst & bus.enb;
        w_rdInRange = ({1'b0, bus.addrb} < DEPTH_W);
        w_fwdMask   = '0;
        if (COLLISION_MODE == 1 && w_wrEn && w_rdEn && bus.addra == bus.addrb) begin
            w_fwdMask = bus.wea;
        end
    end

    always_ff @(posedge clk) begin
        if (w_clrWe) begin
            r_ram[r_cnt] <= '0;
        end else if (w_wrEn) begin
            for (int j = 0; j < NB_COL; j++) begin
                if (bus.wea[j]) begin
                    r_ram[bus.addra][j*BYTE_WIDTH +: BYTE_WIDTH] <= bus.dia[j*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    // Stage 1 keeps the old word plus the forwarded lanes; they are merged after the flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1Valid <= 1'b0;
            r_s1Data  <= '0;
            r_s1Mask  <= '0;
            r_s1Dia   <= '0;
        end else begin
            r_s1Valid <= w_rdEn;
            if (w_rdEn) begin
                r_s1Data <= w_rdInRange ? r_ram[bus.addrb] : '0;
                r_s1Mask <= w_fwdMask;
                r_s1Dia  <= bus.dia;
            end
        end
    end

    always_comb begin
        w_s1Merged = r_s1Data;
        for (int j = 0; j < NB_COL; j++) begin
            if (r_s1Mask[j]) begin
                w_s1Merged[j*BYTE_WIDTH +: BYTE_WIDTH] = r_s1Dia[j*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    if (READ_LATENCY == 1) begin : g_lat1
        assign bus.dob       = w_s1Merged;
        assign bus.dob_valid = r_s1Valid;
    end else if (READ_LATENCY == 2) begin : g_lat2
        logic                  r_s2Valid;
        logic [DATA_WIDTH-1:0] r_s2Data;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_s2Valid <= 1'b0;
                r_s2Data  <= '0;
            end else begin
                r_s2Valid <= r_s1Valid;
                if (r_s1Valid) begin
                    r_s2Data <= w_s1Merged;
                end
            end
        end

        assign bus.dob       = r_s2Data;
        assign bus.dob_valid = r_s2Valid;
    end else begin : g_badLatency
        $error("READ_LATENCY must be 1 or 2");
    end

    assign bus.busy = w_busy;
endmodule

// File: doc/rams_sdp_be_pipe.md
# rams_sdp_be_pipe

Parametrised simple-dual-port block RAM, single clock: port A writes with per-byte enables, port B reads with a selectable 1- or 2-cycle registered latency and a `dob_valid` strobe. It adds a post-reset clear sequencer that zeroes the whole array, so contents are defined without initial blocks. A configurable same-address collision policy completes the block. It is the storage primitive for caches, register-file shadows and I/O buffers in the core.

## Interface
- `DATA_WIDTH`, 32: word width; must be a multiple of `BYTE_WIDTH`.
- `BYTE_WIDTH`, 8: write-enable granularity; `NB_COL = DATA_WIDTH/BYTE_WIDTH`.
- `ADDR_WIDTH`, 10: address width.
- `DATA_DEPTH`, 1024: number of words; must be ≤ 2^ADDR_WIDTH.
- `READ_LATENCY`, 1: 1 or 2; any other value is a synthesis error.
- `COLLISION_MODE`, 0: 0 = read-first (old data); 1 = write-through (new bytes forwarded).
- `CLEAR_ON_RESET`, 1: 1 = zero the array after reset; 0 = no clear.

Ports:
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `ena` input 1: port A enable.
- `wea` input NB_COL: per-byte write enables; lane j covers bits [j*BYTE_WIDTH +: BYTE_WIDTH].
- `addra` input ADDR_WIDTH: write address.
- `dia` input DATA_WIDTH: write data.
- `enb` input 1: read request.
- `addrb` input ADDR_WIDTH: read address.
- `dob` output DATA_WIDTH: registered read data.
- `dob_valid` output 1: `dob` carries the result of a read issued READ_LATENCY cycles earlier.
- `busy` output 1: clear in progress; port A and port B requests are ignored.

## Operation
- States: CLEAR and RUN.
- Reset: an edge with rst=1 sets state to CLEAR if CLEAR_ON_RESET=1, else RUN. It also sets the clear counter to 0, dob to 0, dob_valid to 0, and all internal valid bits to 0. Array contents are not touched by reset itself.
- CLEAR: each edge with rst=0 writes all-zero to `ram[cnt]` and increments `cnt`. The edge that writes address DATA_DEPTH-1 moves the state to RUN. The state is CLEAR exactly when busy=1.
- Requests during CLEAR: ena/wea/enb are ignored. No write occurs, no read is issued, and dob_valid stays 0.
- RUN write: on an edge with ena=1, every lane j with wea[j]=1 is updated from `dia`. Lanes with wea[j]=0 keep their value. When addra ≥ DATA_DEPTH, the write is dropped.
- RUN read: an edge with enb=1 captures `ram[addrb]` into stage 1. When addrb ≥ DATA_DEPTH, the captured data is 0; the read is still valid.
- Collision: a same-edge write and read with addra==addrb, ena=1, enb=1.
  - Mode 0: returned data is the pre-write contents.
  - Mode 1: lanes with wea[j]=1 return `dia` lanes; other lanes return old contents.
  - Implemented as a registered lane mask plus registered dia merged at stage 1. There is no combinational path from dia to dob.
- Hold: when no read completes in a cycle, dob holds its last value and dob_valid=0.
- Reset mid-CLEAR or mid-read: the counter restarts at 0, in-flight reads are discarded, and no dob_valid is produced for them.

## Timing
- Reset release: when CLEAR_ON_RESET=1, busy=1 from the first rst edge. busy falls after the DATA_DEPTH-th edge with rst=0, and the first accepted request is on the following edge.
- CLEAR_ON_RESET=0: busy=0 always.
- Read latency (request on edge t):
  - READ_LATENCY=1: dob and dob_valid update at edge t. Both are visible in the cycle after t.
  - READ_LATENCY=2: stage 2 loads at edge t+1, so the result is visible one cycle later.
- Throughput: one read per cycle. Back-to-back reads produce back-to-back dob_valid pulses in issue order.
- Write-to-read: a write at edge t is visible to a read issued at edge t+1 or later regardless of COLLISION_MODE.
- Stage 2 (READ_LATENCY=2) loads only when stage 1 is valid. Its valid bit is otherwise cleared.

## Test plan
- Reset clear: DATA_WIDTH=32, DATA_DEPTH=16, CLEAR_ON_RESET=1. Pre-write 0xFFFFFFFF to all addresses, pulse rst for 1 cycle.
  - busy stays high for 16 cycles.
  - Reads issued while busy give no dob_valid.
  - After busy falls, reads of all 16 addresses return 0.
- Byte enables: write 0x11223344 to addr 5, then wea=4'b0101 with dia=0xAABBCCDD.
  - Read of addr 5 returns 0x11BB33DD.
- Latency: READ_LATENCY=1 and 2. Issue reads to addrs 1, 2, 3 on consecutive edges.
  - dob_valid is high for 3 consecutive cycles starting 1 or 2 cycles after the first request.
  - Data is in order.
- Collision: addr 7 holds 0x00000000. Same edge: write 0xDEADBEEF with wea=4'b0011, read addr 7.
  - Mode 0 returns 0x00000000.
  - Mode 1 returns 0x0000BEEF.
  - A read on the next edge returns 0x0000BEEF in both modes.
- Reset mid-operation: assert rst at clear count 7 and while a READ_LATENCY=2 read is in flight.
  - No dob_valid appears for the in-flight read.
  - dob=0.
  - The clear restarts and busy lasts a full DATA_DEPTH cycles.
- Out of range: DATA_DEPTH=12, ADDR_WIDTH=4. Write to addr 13, then read addr 13.
  - The read returns 0 with dob_valid=1.
  - Addrs 0–11 are unchanged.
